div_unit: RTL and testbench

//  Iterative radix-2 integer divider for RV32M DIV/DIVU/REM/REMU; the inverse of the single-cycle ALU multiplier.

---
 rtl/div_unit_pkg.sv | 26 ++
 rtl/div_sign_fix.sv | 28 ++
 rtl/div_unit.sv | 127 ++++++++++++
 tb/tb_div_unit.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// Shared encodings for the iterative divider: RV32M op codes and FSM states,
// so execute-stage decode and hazard logic agree with the unit.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } div_state_t;

  function automatic logic op_is_signed(input div_op_t op);
    return ~op[0];
  endfunction

  function automatic logic op_is_rem(input div_op_t op);
    return op[1];
  endfunction

endpackage

// File: rtl/div_sign_fix.sv
// Final sign correction: selects quotient or remainder and restores the
// operand signs stripped before the unsigned restoring loop.
module div_sign_fix
  import div_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] quotient,
  input  logic [DATA_WIDTH-1:0] remainder,
  input  logic                  neg_a,
  input  logic                  neg_b,
  input  logic                  div_zero,
  input  div_op_t               op,
  output logic [DATA_WIDTH-1:0] result
);

  always_comb begin
    // NOTE: default assignment first so no path through this block can infer a latch.
    result = quotient;
    if (op_is_rem(op)) begin
      result = neg_a ? -remainder : remainder;
    end else if ((neg_a != neg_b) && !div_zero) begin
      // Divide-by-zero keeps the all-ones quotient unnegated.
      result = -quotient;
    end
  end

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU, DATA_WIDTH+2 cycle latency.
// Optional `DIV_FAST_SPECIAL_EN resolves divide-by-zero and MIN/-1 at capture in one cycle.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  kill_i,
  input  div_op_t               op_i,
  input  logic [DATA_WIDTH-1:0] dividend_i,
  input  logic [DATA_WIDTH-1:0] divisor_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  div_state_t            state;
  logic [CW-1:0]         count;
  logic [DATA_WIDTH-1:0] rem_q;
  logic [DATA_WIDTH-1:0] quo_q;
  logic [DATA_WIDTH-1:0] dvsr_q;
  div_op_t               op_q;
  logic                  neg_a;
  logic                  neg_b;
  logic                  div_zero;

  logic                  sgn_in;
  logic [DATA_WIDTH-1:0] abs_a;
  logic [DATA_WIDTH-1:0] abs_b;
  logic [DATA_WIDTH:0]   shifted;
  logic                  ge;
  logic [DATA_WIDTH-1:0] rem_diff;
  logic [DATA_WIDTH-1:0] fixed;

  assign sgn_in = op_is_signed(op_i);
  // Two's-complement negation of MIN yields 2^(W-1), which is exact as unsigned.
  assign abs_a  = (sgn_in && dividend_i[DATA_WIDTH-1]) ? -dividend_i : dividend_i;
  assign abs_b  = (sgn_in && divisor_i[DATA_WIDTH-1])  ? -divisor_i  : divisor_i;

  assign shifted  = {rem_q, quo_q[DATA_WIDTH-1]};
  assign ge       = shifted >= {1'b0, dvsr_q};
  // When ge holds the true difference is below 2^W, so W bits suffice.
  assign rem_diff = shifted[DATA_WIDTH-1:0] - dvsr_q;

  assign busy_o = (state != IDLE);

  div_sign_fix #(.DATA_WIDTH(DATA_WIDTH)) u_sign_fix (
    .quotient (quo_q),
    .remainder(rem_q),
    .neg_a    (neg_a),
    .neg_b    (neg_b),
    .div_zero (div_zero),
    .op       (op_q),
    .result   (fixed)
  );

  // NOTE: sequential state uses non-blocking assignments only; every register,
  // datapath included, has a defined reset value so a mid-op reset leaves no stale state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      count    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      op_q     <= DIV;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      div_zero <= 1'b0;
      done_o   <= 1'b0;
      result_o <= '0;
    end else begin
      done_o <= 1'b0;
      if (kill_i) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start_i) begin
              op_q     <= op_i;
              neg_a    <= sgn_in & dividend_i[DATA_WIDTH-1];
              neg_b    <= sgn_in & divisor_i[DATA_WIDTH-1];
              div_zero <= (divisor_i == '0);
              quo_q    <= abs_a;
              dvsr_q   <= abs_b;
              rem_q    <= '0;
              count    <= '0;
`ifdef DIV_FAST_SPECIAL_EN
              if (divisor_i == '0) begin
                result_o <= op_is_rem(op_i) ? dividend_i : '1;
                done_o   <= 1'b1;
              end else if (sgn_in && (dividend_i == {1'b1, {(DATA_WIDTH-1){1'b0}}})
                           && (divisor_i == '1)) begin
                result_o <= op_is_rem(op_i) ? '0 : dividend_i;
                done_o   <= 1'b1;
              end else begin
                state <= RUN;
              end
`else
              state <= RUN;
`endif
            end
          end
          RUN: begin
            rem_q <= ge ? rem_diff : shifted[DATA_WIDTH-1:0];
            quo_q <= {quo_q[DATA_WIDTH-2:0], ge};
            count <= count + 1'b1;
            if (count == LAST) state <= FIX;
          end
          FIX: begin
            result_o <= fixed;
            done_o   <= 1'b1;
            state    <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed RV32M corner cases, kill/reset
// behaviour, held-start pacing and randomized ops against an arithmetic model.
module tb_div_unit;
  import div_unit_pkg::*;

  localparam int W = 32;
  localparam logic [W-1:0] MIN = 32'h8000_0000;
  localparam int NORMAL_LAT = W + 2;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          start_i;
  logic          kill_i;
  div_op_t       op_i;
  logic [W-1:0]  dividend_i;
  logic [W-1:0]  divisor_i;
  logic          busy_o;
  logic          done_o;
  logic [W-1:0]  result_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] last_exp = '0;

  div_unit #(.DATA_WIDTH(W)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (start_i),
    .kill_i    (kill_i),
    .op_i      (op_i),
    .dividend_i(dividend_i),
    .divisor_i (divisor_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .result_o  (result_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // RISC-V M-extension semantics stated directly; SV '/' and '%' truncate toward zero.
  function automatic logic [W-1:0] ref_result(input div_op_t op, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sb;
    logic ovf;
    sa  = a;
    sb  = b;
    ovf = (a == MIN) && (b == '1);
    case (op)
      DIV:     return (b == 0) ? '1 : (ovf ? MIN : W'(sa / sb));
      REM:     return (b == 0) ? a  : (ovf ? '0  : W'(sa % sb));
      DIVU:    return (b == 0) ? '1 : a / b;
      default: return (b == 0) ? a  : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input div_op_t op, input logic [W-1:0] a,
                                     input logic [W-1:0] b);
`ifdef DIV_FAST_SPECIAL_EN
    logic is_signed;
    is_signed = (op == DIV) || (op == REM);
    if (b == 0 || (is_signed && a == MIN && b == '1)) return 1;
`endif
    return NORMAL_LAT;
  endfunction

  // Called #1 after a rising edge with the unit idle; start is sampled in cycle 0.
  task automatic run_op(input string tag, input div_op_t op, input logic [W-1:0] a,
                        input logic [W-1:0] b);
    int cyc;
    logic [W-1:0] exp;
    exp = ref_result(op, a, b);
    op_i = op; dividend_i = a; divisor_i = b; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    cyc = 1;
    while (!done_o && cyc < 100) begin
      @(posedge clk_i); #1;
      cyc++;
    end
    check({tag, " latency"}, W'(cyc), W'(ref_latency(op, a, b)));
    check({tag, " result"}, result_o, exp);
    check({tag, " busy at done"}, {31'b0, busy_o}, '0);
    last_exp = exp;
    @(posedge clk_i); #1;
    check({tag, " done one cycle"}, {31'b0, done_o}, '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int seen;
    int first_done;
    int second_done;
    rst_i = 1'b1; start_i = 1'b0; kill_i = 1'b0; op_i = DIV;
    dividend_i = '0; divisor_i = '0;
    #22;
    check("reset busy", {31'b0, busy_o}, '0);
    check("reset done", {31'b0, done_o}, '0);
    check("reset result", result_o, '0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    run_op("divu 100/7", DIVU, 32'd100, 32'd7);
    run_op("remu 100/7", REMU, 32'd100, 32'd7);
    run_op("div -7/2", DIV, -32'sd7, 32'd2);
    run_op("rem -7/2", REM, -32'sd7, 32'd2);
    run_op("rem 7/-2", REM, 32'd7, -32'sd2);
    run_op("div 5/0", DIV, 32'd5, 32'd0);
    run_op("rem 5/0", REM, 32'd5, 32'd0);
    run_op("divu 5/0", DIVU, 32'd5, 32'd0);
    run_op("remu 5/0", REMU, 32'd5, 32'd0);
    run_op("div min/-1", DIV, MIN, 32'hFFFF_FFFF);
    run_op("rem min/-1", REM, MIN, 32'hFFFF_FFFF);
    run_op("divu max/1", DIVU, 32'hFFFF_FFFF, 32'd1);

    // Kill in cycle 10: no done, idle next cycle, result untouched.
    op_i = DIVU; dividend_i = 32'd1000; divisor_i = 32'd3; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (9) begin @(posedge clk_i); #1; end
    kill_i = 1'b1;
    @(posedge clk_i); #1;
    kill_i = 1'b0;
    check("kill busy", {31'b0, busy_o}, '0);
    check("kill done", {31'b0, done_o}, '0);
    check("kill result kept", result_o, last_exp);
    run_op("after kill", DIVU, 32'd1000, 32'd3);

    // Kill and start together in IDLE: start dropped.
    op_i = DIVU; dividend_i = 32'd50; divisor_i = 32'd5;
    start_i = 1'b1; kill_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0; kill_i = 1'b0;
    check("kill+start busy", {31'b0, busy_o}, '0);
    seen = 0;
    repeat (40) begin @(posedge clk_i); #1; if (done_o) seen++; end
    check("kill+start no done", W'(seen), '0);

    // Held start: one op per IDLE visit, done pulses DATA_WIDTH+2 apart.
    op_i = DIVU; dividend_i = 32'd100; divisor_i = 32'd7; start_i = 1'b1;
    seen = 0; first_done = -1; second_done = -1;
    for (int c = 1; c <= 75; c++) begin
      @(posedge clk_i); #1;
      if (done_o) begin
        seen++;
        if (first_done < 0) first_done = c;
        else if (second_done < 0) second_done = c;
      end
    end
    start_i = 1'b0;
    check("held start done count", W'(seen), 32'd2);
    check("held start first done", W'(first_done), W'(NORMAL_LAT));
    check("held start spacing", W'(second_done - first_done), W'(NORMAL_LAT));
    check("held start result", result_o, 32'd14);

    // Third op is mid-RUN now; reset asynchronously between edges.
    check("mid-run busy", {31'b0, busy_o}, 32'd1);
    #2 rst_i = 1'b1;
    #1;
    check("async reset busy", {31'b0, busy_o}, '0);
    check("async reset done", {31'b0, done_o}, '0);
    check("async reset result", result_o, '0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    run_op("after reset", REM, -32'sd100, 32'd7);

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      div_op_t op;
      a  = $urandom;
      op = div_op_t'($urandom_range(0, 3));
      case ($urandom_range(0, 7))
        0:       b = '0;
        1:       begin a = MIN; b = '1; end
        2:       b = W'($urandom_range(1, 9));
        3:       b = -W'($urandom_range(1, 9));
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      run_op($sformatf("rand%0d op%0d", i, op), op, a, b);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
